// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, bus width defaults and the response
// code used by the master and the APB register slaves.
package apb_pkg;

    localparam int unsigned APB_DATA_WIDTH_DEF = 32;
    localparam int unsigned APB_ADDR_WIDTH_DEF = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef enum logic [1:0] {
        RESP_OKAY    = 2'd0,
        RESP_SLVERR  = 2'd1,
        RESP_TIMEOUT = 2'd2
    } apb_resp_e;

    // A timeout is also reported as a slave error, so it takes priority.
    function automatic apb_resp_e apb_resp_code(input logic slverr, input logic timeout);
        if (timeout) begin
            return RESP_TIMEOUT;
        end else if (slverr) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Clear/enable counter that saturates at LIMIT; expired flags the cycle in
// which an enabled increment reaches LIMIT.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT_C)) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = enable && !clear && (count_d == LIMIT_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3/APB4 initiator: one command in, one SETUP/ACCESS
// transfer out, one response back, with an optional ACCESS-phase timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int unsigned APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                        apb_clk_in,
    input  logic                        apb_rst_in,
    input  logic                        cmd_valid_in,
    output logic                        cmd_ready_out,
    input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
    input  logic                        cmd_write_in,
    input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
    input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
    output logic                        rsp_valid_out,
    input  logic                        rsp_ready_in,
    output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
    output logic                        rsp_slverr_out,
    output logic                        rsp_timeout_out,
    output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
    output logic                        apb_psel_out,
    output logic                        apb_penable_out,
    output logic                        apb_write_out,
    output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
    output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
    input  logic                        apb_ready_in,
    input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
    input  logic                        apb_slverr_in
);

    localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;

    apb_state_e                state_q, state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_slverr_q, rsp_slverr_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      write_q, write_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]         strb_q, strb_d;
    logic                      timeout_expired;

    generate
        if (TIMEOUT_CYCLES == 0) begin : gen_no_timeout
            assign timeout_expired = 1'b0;
        end else begin : gen_timeout
            logic cnt_clear;
            logic cnt_enable;

            // Cleared while in SETUP so the count starts at zero on ACCESS entry.
            assign cnt_clear  = (state_q == SETUP);
            assign cnt_enable = (state_q == ACCESS) && !apb_ready_in;

            apb_timeout_cnt #(
                .LIMIT(TIMEOUT_CYCLES)
            ) u_timeout_cnt (
                .clk     (apb_clk_in),
                .rst     (apb_rst_in),
                .clear   (cnt_clear),
                .enable  (cnt_enable),
                .expired (timeout_expired)
            );
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_ready_q && cmd_valid_in) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr_in;
                    write_d     = cmd_write_in;
                    // Reads leave PWDATA untouched and drive an all-zero PSTRB.
                    if (cmd_write_in) begin
                        wdata_d = cmd_wdata_in;
                        strb_d  = cmd_strb_in;
                    end else begin
                        strb_d  = '0;
                    end
                    psel_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a late-ready slave beats the timeout.
                if (apb_ready_in) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = write_q ? '0 : apb_rdata_in;
                    rsp_slverr_d  = apb_slverr_in;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_expired) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
        if (apb_rst_in) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
        end
    end

    assign cmd_ready_out   = cmd_ready_q;
    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_rdata_out   = rsp_rdata_q;
    assign rsp_slverr_out  = rsp_slverr_q;
    assign rsp_timeout_out = rsp_timeout_q;
    assign apb_addr_out    = addr_q;
    assign apb_psel_out    = psel_q;
    assign apb_penable_out = penable_q;
    assign apb_write_out   = write_q;
    assign apb_wdata_out   = wdata_q;
    assign apb_strb_out    = strb_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a wait-state-programmable APB slave and
// a response scoreboard; TIMEOUT_CYCLES is set to 4.
module tb_apb_master;

    localparam int T = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] apb_addr;
    logic        psel;
    logic        penable;
    logic        apb_write;
    logic [31:0] apb_wdata;
    logic [3:0]  apb_strb;
    logic        apb_ready;
    logic [31:0] apb_rdata;
    logic        apb_slverr;

    int          checks = 0;
    int          errors = 0;
    rsp_t        sb[$];
    logic [31:0] last_wdata = '0;

    int          slv_wait = 0;
    bit          slv_hang = 1'b0;
    bit          slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt;

    always #5 clk = ~clk;

    apb_master #(
        .APB_DATA_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .apb_clk_in      (clk),
        .apb_rst_in      (rst),
        .cmd_valid_in    (cmd_valid),
        .cmd_ready_out   (cmd_ready),
        .cmd_addr_in     (cmd_addr),
        .cmd_write_in    (cmd_write),
        .cmd_wdata_in    (cmd_wdata),
        .cmd_strb_in     (cmd_strb),
        .rsp_valid_out   (rsp_valid),
        .rsp_ready_in    (rsp_ready),
        .rsp_rdata_out   (rsp_rdata),
        .rsp_slverr_out  (rsp_slverr),
        .rsp_timeout_out (rsp_timeout),
        .apb_addr_out    (apb_addr),
        .apb_psel_out    (psel),
        .apb_penable_out (penable),
        .apb_write_out   (apb_write),
        .apb_wdata_out   (apb_wdata),
        .apb_strb_out    (apb_strb),
        .apb_ready_in    (apb_ready),
        .apb_rdata_in    (apb_rdata),
        .apb_slverr_in   (apb_slverr)
    );

    // Slave: PREADY after slv_wait stalled ACCESS cycles; junk data and a set
    // PSLVERR whenever PREADY is low, which the master must ignore.
    assign apb_ready  = psel && penable && !slv_hang && (acc_cnt == slv_wait);
    assign apb_rdata  = apb_ready ? slv_rdata : 32'hDEAD_BEEF;
    assign apb_slverr = apb_ready ? slv_err : 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 0;
        end else if (psel && penable && !apb_ready) begin
            acc_cnt <= acc_cnt + 1;
        end else begin
            acc_cnt <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd_ready();
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) begin
            tick();
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input int w, input bit hang, input bit err,
                        input logic [31:0] rd, input int hold);
        rsp_t e;
        int   lat;
        int   pen;
        slv_wait  = w;
        slv_hang  = hang;
        slv_err   = err;
        slv_rdata = rd;
        e.rdata   = (wr || hang) ? 32'h0 : rd;
        e.slverr  = hang ? 1'b1 : err;
        e.timeout = hang;
        sb.push_back(e);

        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_valid = 1'b1;
        wait_cmd_ready();
        tick();
        cmd_valid = 1'b0;

        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("paddr", apb_addr, addr);
        check("pwrite", apb_write, wr);
        check("pstrb", apb_strb, wr ? st : 4'h0);
        check("pwdata", apb_wdata, wr ? wd : last_wdata);
        if (wr) last_wdata = wd;

        lat = 0;
        pen = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            if (penable === 1'b1) pen++;
            if (psel === 1'b1) check("paddr_stable", apb_addr, addr);
            tick();
            lat++;
        end
        check("rsp_latency", lat, hang ? (1 + T) : (2 + w));
        check("penable_cycles", pen, hang ? T : (w + 1));
        check("resp_psel", psel, 0);
        check("resp_penable", penable, 0);

        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < hold; i++) begin
                cmd_valid = 1'b1;
                cmd_addr  = ~addr;
                tick();
                check("hold_rsp_valid", rsp_valid, 1);
                check("hold_rdata", rsp_rdata, e.rdata);
                check("hold_cmd_ready", cmd_ready, 0);
                check("hold_psel", psel, 0);
            end
            cmd_valid = 1'b0;
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_slverr", rsp_slverr, e.slverr);
            check("rsp_timeout", rsp_timeout, e.timeout);
        end
        $display("xfer addr=%08h wr=%0d rdata=%08h slverr=%0d timeout=%0d lat=%0d",
                 addr, wr, rsp_rdata, rsp_slverr, rsp_timeout, lat);

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("after_rsp_valid", rsp_valid, 0);
        check("after_cmd_ready", cmd_ready, 1);
        check("after_psel", psel, 0);
    endtask

    initial begin
        int stale;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        rst = 1'b1;
        tick();
        tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_paddr", apb_addr, 0);
        check("rst_pstrb", apb_strb, 0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write; slave drives nonzero PRDATA that must not leak.
        xfer(32'hA030_0004, 1'b1, 32'h0000_00A5, 4'hF, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0);
        // Read with two wait states.
        xfer(32'hA030_0008, 1'b0, 32'h1111_1111, 4'hF, 2, 1'b0, 1'b0, 32'h1234_5678, 0);
        // Slave error on read to offset 0x40.
        xfer(32'hA030_0040, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b1, 32'hCAFE_0040, 0);
        // Hung slave: timeout after T ACCESS cycles.
        xfer(32'hA030_000C, 1'b0, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'h7777_7777, 0);
        // PREADY on the T-th ACCESS cycle wins over the timeout.
        xfer(32'hA030_0010, 1'b0, 32'h0, 4'hF, T - 1, 1'b0, 1'b0, 32'h0BAD_F00D, 0);
        // Response back-pressured for five cycles with a competing command.
        xfer(32'hA030_0014, 1'b1, 32'h0000_55AA, 4'h3, 1, 1'b0, 1'b0, 32'h0, 5);

        // Reset pulsed during ACCESS of a read to a hung slave.
        slv_hang  = 1'b1;
        cmd_addr  = 32'hA030_0018;
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        wait_cmd_ready();
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_penable", penable, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b0;
        slv_hang = 1'b0;
        last_wdata = '0;
        tick();
        check("rst_release_cmd_ready", cmd_ready, 1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || psel !== 1'b0) stale++;
        end
        check("no_stale_rsp", stale, 0);
        $display("xfer addr=a0300018 wr=0 aborted by reset stale=%0d", stale);

        // Normal operation resumes after the reset.
        xfer(32'hA030_001C, 1'b0, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h600D_CAFE, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
